// File: rtl/serial_link_arb_pkg.sv
// Shared types, default widths and round-robin helper for serial_link_arbiter.
// Grant counters are built only when SERIAL_LINK_ARB_STATS_EN is defined.
package serial_link_arb_pkg;
    localparam int unsigned NUM_REQ_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MAX_REQ        = 32;
    localparam int unsigned MAX_IDX_W      = $clog2(MAX_REQ);
    localparam int unsigned REQ_IDX_W      = $clog2(NUM_REQ_DEF);
    localparam int unsigned BIT_CNT_W      = $clog2(DATA_WIDTH_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // First valid index strictly after ptr (wrapping); returns ptr when nothing is valid.
    function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        num);
        logic [MAX_IDX_W-1:0] idx;
        rr_next = ptr;
        for (int unsigned k = num; k >= 1; k--) begin
            idx = MAX_IDX_W'((ptr + k) % num);
            if (valid[idx]) rr_next = 32'(idx);
        end
    endfunction
endpackage

// File: rtl/serial_link_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest-priority slot is the one at ptr.
module rr_picker
    import serial_link_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] index_c,
    output logic                       any_c
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] valid_ext;
    int unsigned        win;

    always_comb begin
        valid_ext = MAX_REQ'(valid);
        win       = rr_next(valid_ext, 32'(ptr), NUM_REQ);
        any_c     = |valid;
        index_c   = IDX_W'(win);
        grant_c   = any_c ? (NUM_REQ'(1) << index_c) : '0;
    end
endmodule

// File: rtl/serial_link_arbiter.sv
// Round-robin scheduler serialising one requester word per grant, MSB-first, onto a shared lane.
// Define SERIAL_LINK_ARB_STATS_EN to build saturating per-requester grant counters.
module serial_link_arbiter
    import serial_link_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          link_ready_i,
    output logic                          serial_out_o,
    output logic                          enable_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt_o
);
    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid   (req_valid_i),
        .ptr     (ptr_q),
        .grant_c (pick_grant),
        .index_c (pick_idx),
        .any_c   (pick_any)
    );

    // Pointer resets to the last slot so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        serial_out_o = 1'b0;
        enable_o     = 1'b0;
        start_o      = 1'b0;
        busy_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    shreg_d    = req_data_i[32'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    bit_cnt_d  = '0;
                    ptr_d      = pick_idx;
                    grant_id_d = pick_idx;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                busy_o       = 1'b1;
                serial_out_o = shreg_q[DATA_WIDTH-1];
                start_o      = (bit_cnt_q == '0);
                enable_o     = link_ready_i;
                if (link_ready_i) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                busy_o    = 1'b1;
                gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept pulse is held off while reset is asserted so every output reads 0 in reset.
    assign req_ready_o = (state_q == IDLE && !rst_i) ? pick_grant : '0;
    assign grant_id_o  = grant_id_q;

`ifdef SERIAL_LINK_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (req_ready_o[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
        assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`else
    assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_serial_link_arbiter.sv
// Self-checking bench for serial_link_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the round-robin lane.
module tb_serial_link_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int CW2 = 2;
    localparam int GAP1 = 1;
`ifdef SERIAL_LINK_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic clk, rst;

    logic [N-1:0]    valid_m, ready_m;
    logic [N*DW-1:0] data_m;
    logic            link_m, ser_m, en_m, st_m, busy_m;
    logic [1:0]      gid_m;
    logic [N*CW-1:0] cnt_m;

    logic [N-1:0]     valid_2, ready_2;
    logic [N*DW-1:0]  data_2;
    logic             ser_2, en_2, st_2, busy_2;
    logic [1:0]       gid_2;
    logic [N*CW2-1:0] cnt_2;

    logic [N-1:0]    valid_0, ready_0;
    logic [N*DW-1:0] data_0;
    logic            ser_0, en_0, st_0, busy_0;
    logic [1:0]      gid_0;
    logic [N*CW-1:0] cnt_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP1), .CNT_WIDTH(CW)) u_main (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid_m), .req_data_i(data_m), .req_ready_o(ready_m),
        .link_ready_i(link_m), .serial_out_o(ser_m), .enable_o(en_m), .start_o(st_m),
        .busy_o(busy_m), .grant_id_o(gid_m), .grant_cnt_o(cnt_m));

    serial_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(2), .CNT_WIDTH(CW2)) u_gap2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid_2), .req_data_i(data_2), .req_ready_o(ready_2),
        .link_ready_i(1'b1), .serial_out_o(ser_2), .enable_o(en_2), .start_o(st_2),
        .busy_o(busy_2), .grant_id_o(gid_2), .grant_cnt_o(cnt_2));

    serial_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(0), .CNT_WIDTH(CW)) u_gap0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid_0), .req_data_i(data_0), .req_ready_o(ready_0),
        .link_ready_i(1'b1), .serial_out_o(ser_0), .enable_o(en_0), .start_o(st_0),
        .busy_o(busy_0), .grant_id_o(gid_0), .grant_cnt_o(cnt_0));

    // Loopback deserializer on the main lane: start restarts the word, DW enabled bits complete it.
    logic [DW-1:0] rx_sh   = '0;
    logic [DW-1:0] rx_word = '0;
    int            rx_bits = 0;
    int            rx_cnt  = 0;
    always @(posedge clk) begin
        if (en_m) begin
            if (st_m) begin
                rx_sh   <= DW'(ser_m);
                rx_bits <= 1;
            end else begin
                rx_sh   <= {rx_sh[DW-2:0], ser_m};
                rx_bits <= rx_bits + 1;
                if (rx_bits == DW - 1) begin
                    rx_word <= {rx_sh[DW-2:0], ser_m};
                    rx_cnt  <= rx_cnt + 1;
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1; valid_m = '0; valid_2 = '0; valid_0 = '0; link_m = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs until the main DUT pulses ready; idx = winner, -2 if not one-hot, -1 on timeout.
    task automatic wait_accept(output int idx);
        bit done = 1'b0;
        idx = -1;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (ready_m != '0) begin
                done = 1'b1;
                idx  = -2;
                if ($onehot(ready_m))
                    for (int n = 0; n < N; n++) if (ready_m[n]) idx = n;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_m = '1; valid_2 = '1; valid_0 = '1; link_m = 1'b1;
        data_m = 32'($urandom); data_2 = 32'($urandom); data_0 = 32'($urandom);
        @(negedge clk);
        #1;
        tests++;
        if (ready_m !== '0) begin fails++; $display("FAIL reset_ready got %b want 0000", ready_m); end
        tests++;
        if ({ser_m, en_m, st_m, busy_m} !== 4'b0) begin
            fails++; $display("FAIL reset_lane got %b want 0000", {ser_m, en_m, st_m, busy_m});
        end
        tests++;
        if (gid_m !== 2'd0 || cnt_m !== '0) begin
            fails++; $display("FAIL reset_gid_cnt got gid=%0d cnt=%h want 0/0", gid_m, cnt_m);
        end
        tests++;
        if (ready_2 !== '0 || ready_0 !== '0) begin
            fails++; $display("FAIL reset_ready_aux got %b/%b want 0000/0000", ready_2, ready_0);
        end
        @(negedge clk);
        rst = 1'b0; valid_m = '0; valid_2 = '0; valid_0 = '0;
        #1;
        tests++;
        if (busy_m !== 1'b0 || ready_m !== '0) begin
            fails++; $display("FAIL reset_idle got busy=%b ready=%b want 0/0000", busy_m, ready_m);
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [DW-1:0] w = 8'hA5;
        int rx0;
        apply_reset();
        rx0 = rx_cnt;
        valid_m = 4'b0001; data_m = 32'h0000_00A5;
        #1;
        tests++;
        if (ready_m !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", ready_m); end
        @(negedge clk);
        valid_m = '0;
        for (int b = 0; b < DW; b++) begin
            #1;
            tests++;
            if ({ser_m, st_m, en_m, busy_m, ready_m} !== {w[DW-1-b], (b == 0), 1'b1, 1'b1, 4'b0}) begin
                fails++;
                $display("FAIL single_bit%0d got ser/st/en/busy/rdy=%b want %b", b,
                         {ser_m, st_m, en_m, busy_m, ready_m}, {w[DW-1-b], (b == 0), 1'b1, 1'b1, 4'b0});
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if ({busy_m, en_m, st_m, ser_m} !== 4'b1000) begin
            fails++; $display("FAIL single_gap got busy/en/st/ser=%b want 1000", {busy_m, en_m, st_m, ser_m});
        end
        @(negedge clk);
        #1;
        tests++;
        if (busy_m !== 1'b0) begin fails++; $display("FAIL single_idle got busy=%b want 0", busy_m); end
        tests++;
        if (rx_cnt !== rx0 + 1 || rx_word !== 8'hA5 || gid_m !== 2'd0) begin
            fails++; $display("FAIL single_rx got n=%0d word=%h gid=%0d want n=%0d word=a5 gid=0",
                              rx_cnt - rx0, rx_word, gid_m, 1);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int idx;
        int exp_seq[6] = '{0, 1, 0, 1, 3, 0};
        apply_reset();
        valid_m = 4'b0011; data_m = 32'h0000_2211;
        for (int g = 0; g < 6; g++) begin
            if (g == 4) valid_m = 4'b1001;
            wait_accept(idx);
            tests++;
            if (idx !== exp_seq[g] || gid_m !== 2'(exp_seq[g])) begin
                fails++; $display("FAIL fair_grant%0d got idx=%0d gid=%0d want %0d", g, idx, gid_m, exp_seq[g]);
            end
        end
        valid_m = '0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] w = 8'hA5;
        int idx, rx0;
        apply_reset();
        rx0 = rx_cnt;
        valid_m = 4'b0001; data_m = 32'h0000_00A5;
        wait_accept(idx);
        valid_m = '0;
        for (int b = 0; b < DW; b++) begin
            if (b == 0 || b == 4) begin
                for (int s = 0; s < 3; s++) begin
                    link_m = 1'b0;
                    #1;
                    tests++;
                    if ({st_m, en_m, ser_m, busy_m} !== {(b == 0), 1'b0, w[DW-1-b], 1'b1}) begin
                        fails++; $display("FAIL stall_b%0d_s%0d got st/en/ser/busy=%b want %b", b, s,
                                          {st_m, en_m, ser_m, busy_m}, {(b == 0), 1'b0, w[DW-1-b], 1'b1});
                    end
                    @(negedge clk);
                end
            end
            link_m = 1'b1;
            #1;
            tests++;
            if ({st_m, en_m, ser_m} !== {(b == 0), 1'b1, w[DW-1-b]}) begin
                fails++; $display("FAIL stall_go_b%0d got st/en/ser=%b want %b", b,
                                  {st_m, en_m, ser_m}, {(b == 0), 1'b1, w[DW-1-b]});
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (rx_cnt !== rx0 + 1 || rx_word !== 8'hA5) begin
            fails++; $display("FAIL stall_rx got n=%0d word=%h want 1 a5", rx_cnt - rx0, rx_word);
        end
    endtask

    task automatic test_gap();
        int t2[3], t0[3];
        int k2 = 0, k0 = 0, gap2 = 0, gap0 = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin t2[i] = -100; t0[i] = -100; end
        valid_2 = 4'b0001; data_2 = 32'h0000_005A;
        valid_0 = 4'b0001; data_0 = 32'h0000_00C3;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready_2 != '0 && k2 < 3) begin t2[k2] = c; k2++; end
            else if (k2 == 1 && busy_2 && !en_2) gap2++;
            if (ready_0 != '0 && k0 < 3) begin t0[k0] = c; k0++; end
            else if (k0 == 1 && busy_0 && !en_0) gap0++;
            @(negedge clk);
        end
        valid_2 = '0; valid_0 = '0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (t2[i+1] - t2[i] !== DW + 2 + 1) begin
                fails++; $display("FAIL gap2_period%0d got %0d want %0d", i, t2[i+1] - t2[i], DW + 3);
            end
            tests++;
            if (t0[i+1] - t0[i] !== DW + 1) begin
                fails++; $display("FAIL gap0_period%0d got %0d want %0d", i, t0[i+1] - t0[i], DW + 1);
            end
        end
        tests++;
        if (gap2 !== 2 || gap0 !== 0) begin
            fails++; $display("FAIL gap_idle_cycles got %0d/%0d want 2/0", gap2, gap0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int idx, rx0;
        apply_reset();
        valid_m = 4'b0100; data_m = 32'h003C_0096;
        wait_accept(idx);
        tests++;
        if (idx !== 2) begin fails++; $display("FAIL midrst_first got %0d want 2", idx); end
        valid_m = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (st_m !== 1'b0 || busy_m !== 1'b1) begin
            fails++; $display("FAIL midrst_bit3 got st=%b busy=%b want 0/1", st_m, busy_m);
        end
        rst = 1'b1; valid_m = 4'b0101;
        #1;
        tests++;
        if ({ser_m, en_m, st_m, busy_m, ready_m, gid_m} !== 10'b0) begin
            fails++; $display("FAIL midrst_outputs got %b want 0", {ser_m, en_m, st_m, busy_m, ready_m, gid_m});
        end
        rx0 = rx_cnt;
        @(negedge clk);
        rst = 1'b0;
        wait_accept(idx);
        tests++;
        if (idx !== 0) begin fails++; $display("FAIL midrst_regrant got %0d want 0", idx); end
        valid_m = '0;
        repeat (10) @(negedge clk);
        tests++;
        if (rx_cnt !== rx0 + 1 || rx_word !== 8'h96) begin
            fails++; $display("FAIL midrst_rx got n=%0d word=%h want 1 96", rx_cnt - rx0, rx_word);
        end
    endtask

    task automatic test_stats();
        int nm = 0, n2 = 0;
        logic [N*CW-1:0]  e_m = '0;
        logic [N*CW2-1:0] e_2 = '0;
        apply_reset();
        data_m = 32'h0077_0000; data_2 = 32'h0077_0000;
        for (int c = 0; c < 100 && (nm < 5 || n2 < 5); c++) begin
            valid_m = (nm < 5) ? 4'b0100 : 4'b0000;
            valid_2 = (n2 < 5) ? 4'b0100 : 4'b0000;
            #1;
            if (ready_m[2]) nm++;
            if (ready_2[2]) n2++;
            @(negedge clk);
        end
        valid_m = '0; valid_2 = '0;
        @(negedge clk);
        e_m[2*CW +: CW]   = STATS ? CW'(5) : CW'(0);
        e_2[2*CW2 +: CW2] = STATS ? CW2'(3) : CW2'(0);
        tests++;
        if (nm !== 5 || n2 !== 5) begin fails++; $display("FAIL stats_grants got %0d/%0d want 5/5", nm, n2); end
        tests++;
        if (cnt_m !== e_m) begin fails++; $display("FAIL stats_cnt got %h want %h", cnt_m, e_m); end
        tests++;
        if (cnt_2 !== e_2) begin fails++; $display("FAIL stats_sat got %h want %h", cnt_2, e_2); end
    endtask

    // Model tracks bits remaining in the frame and gap cycles left, not the shifter itself.
    task automatic test_random();
        int            m_ptr = N - 1, m_bits = 0, m_gap = 0, m_grant = 0;
        logic [DW-1:0] m_word = '0;
        int            m_cnt[N];
        bit            rv[N];
        logic [DW-1:0] rd[N];
        apply_reset();
        for (int n = 0; n < N; n++) begin m_cnt[n] = 0; rv[n] = 1'b0; rd[n] = '0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            int              win;
            logic [N-1:0]    e_ready;
            logic [3:0]      e_lane;
            logic [N*CW-1:0] e_cnt;
            for (int n = 0; n < N; n++) begin
                if (!rv[n]) begin
                    if ($urandom_range(3) == 0) begin rv[n] = 1'b1; rd[n] = DW'($urandom); end
                end else if ($urandom_range(15) == 0) begin
                    rv[n] = 1'b0;
                end
                valid_m[n] = rv[n];
                data_m[n*DW +: DW] = rd[n];
            end
            link_m = ($urandom_range(3) != 0);
            win = -1; e_ready = '0; e_lane = 4'b0;
            if (m_bits > 0) e_lane = {m_word[m_bits-1], link_m, (m_bits == DW), 1'b1};
            else if (m_gap > 0) e_lane = 4'b0001;
            else
                for (int k = 1; k <= N; k++)
                    if (win < 0 && rv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            if (win >= 0) e_ready = N'(1) << win;
            for (int n = 0; n < N; n++) e_cnt[n*CW +: CW] = STATS ? CW'(m_cnt[n]) : CW'(0);
            #1;
            tests++;
            if (ready_m !== e_ready) begin
                fails++; $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, ready_m, e_ready);
            end
            tests++;
            if ({ser_m, en_m, st_m, busy_m} !== e_lane) begin
                fails++; $display("FAIL rnd_lane cyc%0d got ser/en/st/busy=%b want %b", cyc,
                                  {ser_m, en_m, st_m, busy_m}, e_lane);
            end
            tests++;
            if (gid_m !== 2'(m_grant) || cnt_m !== e_cnt) begin
                fails++; $display("FAIL rnd_gid_cnt cyc%0d got %0d/%h want %0d/%h", cyc, gid_m, cnt_m, m_grant, e_cnt);
            end
            if (m_bits > 0) begin
                if (link_m) begin
                    m_bits--;
                    if (m_bits == 0) m_gap = GAP1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (win >= 0) begin
                m_ptr = win; m_grant = win; m_word = rd[win]; m_bits = DW;
                m_cnt[win]++; rv[win] = 1'b0;
            end
            @(negedge clk);
        end
        valid_m = '0; link_m = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fairness();
        test_stall();
        test_gap();
        test_reset_mid_frame();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
